// File: rtl/y86_pkg.sv
// Shared Y86-64 pipeline types: stage register layouts, status and icode constants,
// and the bubble (NOP) value for each stage register.
package y86_pkg;

  localparam int DATA_W = 64;

  localparam logic [2:0] AOK = 3'd1;
  localparam logic [2:0] HLT = 3'd2;
  localparam logic [2:0] ADR = 3'd3;
  localparam logic [2:0] INS = 3'd4;

  localparam logic [3:0] NOP    = 4'h1;
  localparam logic [3:0] MRMOVQ = 4'h5;
  localparam logic [3:0] JXX    = 4'h7;
  localparam logic [3:0] RET    = 4'h9;
  localparam logic [3:0] POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic [2:0]        stat;
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [3:0]        rA;
    logic [3:0]        rB;
    logic [DATA_W-1:0] valC;
    logic [DATA_W-1:0] valP;
  } d_reg_t;

  typedef struct packed {
    logic [2:0]        stat;
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [DATA_W-1:0] valC;
    logic [DATA_W-1:0] valA;
    logic [DATA_W-1:0] valB;
    logic [3:0]        dstE;
    logic [3:0]        dstM;
    logic [3:0]        srcA;
    logic [3:0]        srcB;
  } e_reg_t;

  typedef struct packed {
    logic [2:0]        stat;
    logic [3:0]        icode;
    logic              Cnd;
    logic [DATA_W-1:0] valE;
    logic [DATA_W-1:0] valA;
    logic [3:0]        dstE;
    logic [3:0]        dstM;
  } m_reg_t;

  typedef struct packed {
    logic [2:0]        stat;
    logic [3:0]        icode;
    logic [DATA_W-1:0] valE;
    logic [DATA_W-1:0] valM;
    logic [3:0]        dstE;
    logic [3:0]        dstM;
  } w_reg_t;

  localparam d_reg_t D_BUBBLE = '{stat: AOK, icode: NOP, ifun: 4'h0, rA: RNONE, rB: RNONE,
                                  valC: '0, valP: '0};
  localparam e_reg_t E_BUBBLE = '{stat: AOK, icode: NOP, ifun: 4'h0, valC: '0, valA: '0,
                                  valB: '0, dstE: RNONE, dstM: RNONE, srcA: RNONE, srcB: RNONE};
  localparam m_reg_t M_BUBBLE = '{stat: AOK, icode: NOP, Cnd: 1'b0, valE: '0, valA: '0,
                                  dstE: RNONE, dstM: RNONE};
  localparam w_reg_t W_BUBBLE = '{stat: AOK, icode: NOP, valE: '0, valM: '0,
                                  dstE: RNONE, dstM: RNONE};

endpackage

// File: rtl/pipe_regs_if.sv
// Control, stage-input and stage-output bundle of the pipeline register bank.
// The slave modport is the register bank, the master side is the pipeline control.
interface pipe_regs_if #(
  parameter int WORD = 64,
  parameter int CNTW = 32
);
  import y86_pkg::*;

  logic            F_stall;
  logic            D_stall;
  logic            W_stall;
  logic            D_bubble;
  logic            E_bubble;
  logic            M_bubble;
  logic [WORD-1:0] f_predPC;
  d_reg_t          d_in;
  e_reg_t          e_in;
  m_reg_t          m_in;
  w_reg_t          w_in;
  logic [WORD-1:0] F_predPC;
  d_reg_t          D_out;
  e_reg_t          E_out;
  m_reg_t          M_out;
  w_reg_t          W_out;
  logic [CNTW-1:0] stall_cnt;
  logic [CNTW-1:0] bubble_cnt;

  modport master (
    output F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble,
    output f_predPC, d_in, e_in, m_in, w_in,
    input  F_predPC, D_out, E_out, M_out, W_out, stall_cnt, bubble_cnt
  );

  modport slave (
    input  F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble,
    input  f_predPC, d_in, e_in, m_in, w_in,
    output F_predPC, D_out, E_out, M_out, W_out, stall_cnt, bubble_cnt
  );
endinterface

// File: rtl/pipe_reg.sv
// One pipeline stage register: reset and bubble load BUBBLE, stall holds, otherwise loads d.
// Stall deliberately outranks bubble so a stalled stage never loses its instruction.
module pipe_reg #(
  parameter int           W      = 8,
  parameter logic [W-1:0] BUBBLE = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= BUBBLE;
    else if (stall)
      q <= q;
    else if (bubble)
      q <= BUBBLE;
    else
      q <= d;
  end

endmodule

// File: rtl/pipe_regs.sv
// Y86-64 F/D/E/M/W pipeline register bank with saturating stall and bubble event counters.
module pipe_regs
  import y86_pkg::*;
#(
  parameter int WORD = 64,
  parameter int CNTW = 32
) (
  input logic         clk,
  input logic         rst,
  pipe_regs_if.slave  bus
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  logic            any_stall;
  logic            any_bubble;
  logic [CNTW-1:0] stall_cnt_q;
  logic [CNTW-1:0] bubble_cnt_q;

  pipe_reg #(.W(WORD), .BUBBLE('0)) f_reg (
    .clk(clk), .rst(rst), .stall(bus.F_stall), .bubble(1'b0),
    .d(bus.f_predPC), .q(bus.F_predPC)
  );

  pipe_reg #(.W($bits(d_reg_t)), .BUBBLE(D_BUBBLE)) d_reg (
    .clk(clk), .rst(rst), .stall(bus.D_stall), .bubble(bus.D_bubble),
    .d(bus.d_in), .q(bus.D_out)
  );

  pipe_reg #(.W($bits(e_reg_t)), .BUBBLE(E_BUBBLE)) e_reg (
    .clk(clk), .rst(rst), .stall(1'b0), .bubble(bus.E_bubble),
    .d(bus.e_in), .q(bus.E_out)
  );

  pipe_reg #(.W($bits(m_reg_t)), .BUBBLE(M_BUBBLE)) m_reg (
    .clk(clk), .rst(rst), .stall(1'b0), .bubble(bus.M_bubble),
    .d(bus.m_in), .q(bus.M_out)
  );

  pipe_reg #(.W($bits(w_reg_t)), .BUBBLE(W_BUBBLE)) w_reg (
    .clk(clk), .rst(rst), .stall(bus.W_stall), .bubble(1'b0),
    .d(bus.w_in), .q(bus.W_out)
  );

  assign any_stall  = bus.F_stall | bus.D_stall | bus.W_stall;
  assign any_bubble = bus.D_bubble | bus.E_bubble | bus.M_bubble;

  // One count per cycle with any event, however many stages it touches; stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (any_stall && stall_cnt_q != CNT_MAX)
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
      if (any_bubble && bubble_cnt_q != CNT_MAX)
        bubble_cnt_q <= bubble_cnt_q + CNT_ONE;
    end
  end

  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_regs.sv
// Directed bench for pipe_regs: a default-width bank for the pipeline scenarios and a
// 4-bit-counter bank for counter saturation.
module tb_pipe_regs;
  import y86_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic sat_rst;
  int   check_count = 0;
  int   error_count = 0;

  always #5 clk = ~clk;

  pipe_regs_if #(.WORD(64), .CNTW(32)) bus ();
  pipe_regs_if #(.WORD(64), .CNTW(4))  sat ();

  pipe_regs #(.WORD(64), .CNTW(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  pipe_regs #(.WORD(64), .CNTW(4))  dut_sat (.clk(clk), .rst(sat_rst), .bus(sat));

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic fs, input logic ds, input logic ws,
                               input logic db, input logic eb, input logic mb);
    bus.F_stall  = fs;
    bus.D_stall  = ds;
    bus.W_stall  = ws;
    bus.D_bubble = db;
    bus.E_bubble = eb;
    bus.M_bubble = mb;
  endtask

  // Advance one edge and settle so outputs are sampled away from the clock edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    sat_rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    bus.f_predPC = 64'h1234;
    bus.d_in     = '1;
    bus.e_in     = '1;
    bus.m_in     = '1;
    bus.w_in     = '1;
    sat.F_stall  = 1'b0;
    sat.D_stall  = 1'b0;
    sat.W_stall  = 1'b0;
    sat.D_bubble = 1'b0;
    sat.E_bubble = 1'b0;
    sat.M_bubble = 1'b0;
    sat.f_predPC = '0;
    sat.d_in     = '0;
    sat.e_in     = '0;
    sat.m_in     = '0;
    sat.w_in     = '0;

    tick();
    tick();
    checkOutput("rst_F_predPC", bus.F_predPC, 64'h0);
    checkOutput("rst_D_icode", bus.D_out.icode, 64'h1);
    checkOutput("rst_D_stat", bus.D_out.stat, 64'h1);
    checkOutput("rst_D_rA", bus.D_out.rA, 64'hF);
    checkOutput("rst_D_valC", bus.D_out.valC, 64'h0);
    checkOutput("rst_E_icode", bus.E_out.icode, 64'h1);
    checkOutput("rst_E_srcB", bus.E_out.srcB, 64'hF);
    checkOutput("rst_M_icode", bus.M_out.icode, 64'h1);
    checkOutput("rst_M_dstE", bus.M_out.dstE, 64'hF);
    checkOutput("rst_W_icode", bus.W_out.icode, 64'h1);
    checkOutput("rst_W_dstM", bus.W_out.dstM, 64'hF);
    checkOutput("rst_stall_cnt", bus.stall_cnt, 64'h0);
    checkOutput("rst_bubble_cnt", bus.bubble_cnt, 64'h0);

    rst = 1'b0;
    bus.f_predPC = 64'h100;
    bus.d_in = '{stat: AOK, icode: 4'h6, ifun: 4'h0, rA: 4'h2, rB: 4'h3,
                 valC: 64'h11, valP: 64'h102};
    bus.e_in = '0;
    bus.e_in.stat = AOK; bus.e_in.icode = 4'h2; bus.e_in.valA = 64'h22; bus.e_in.dstE = 4'h4;
    bus.m_in = '0;
    bus.m_in.stat = AOK; bus.m_in.icode = 4'h3; bus.m_in.valE = 64'h33;
    bus.w_in = '0;
    bus.w_in.stat = AOK; bus.w_in.icode = 4'h4; bus.w_in.valM = 64'h44;
    tick();
    checkOutput("load_F_predPC", bus.F_predPC, 64'h100);
    checkOutput("load_D_icode", bus.D_out.icode, 64'h6);
    checkOutput("load_D_valP", bus.D_out.valP, 64'h102);
    checkOutput("load_E_valA", bus.E_out.valA, 64'h22);
    checkOutput("load_M_valE", bus.M_out.valE, 64'h33);
    checkOutput("load_W_valM", bus.W_out.valM, 64'h44);
    checkOutput("load_stall_cnt", bus.stall_cnt, 64'h0);

    // Load-use hazard: hold F and D, inject a bubble into E.
    bus.f_predPC      = 64'h200;
    bus.d_in.icode    = MRMOVQ;
    bus.d_in.valP     = 64'h202;
    bus.e_in.icode    = 4'h8;
    bus.m_in.valE     = 64'h55;
    bus.w_in.valM     = 64'h66;
    applyStimulus(1, 1, 0, 0, 1, 0);
    tick();
    checkOutput("lu_F_predPC", bus.F_predPC, 64'h100);
    checkOutput("lu_D_icode", bus.D_out.icode, 64'h6);
    checkOutput("lu_D_valP", bus.D_out.valP, 64'h102);
    checkOutput("lu_E_icode", bus.E_out.icode, 64'h1);
    checkOutput("lu_E_valA", bus.E_out.valA, 64'h0);
    checkOutput("lu_E_dstE", bus.E_out.dstE, 64'hF);
    checkOutput("lu_M_valE", bus.M_out.valE, 64'h55);
    checkOutput("lu_W_valM", bus.W_out.valM, 64'h66);
    checkOutput("lu_stall_cnt", bus.stall_cnt, 64'h1);
    checkOutput("lu_bubble_cnt", bus.bubble_cnt, 64'h1);

    // Mispredicted branch: squash D and E in the same cycle.
    bus.d_in.icode = JXX;
    bus.e_in.icode = JXX;
    applyStimulus(0, 0, 0, 1, 1, 0);
    tick();
    checkOutput("mp_F_predPC", bus.F_predPC, 64'h200);
    checkOutput("mp_D_icode", bus.D_out.icode, 64'h1);
    checkOutput("mp_D_rA", bus.D_out.rA, 64'hF);
    checkOutput("mp_E_icode", bus.E_out.icode, 64'h1);
    checkOutput("mp_bubble_cnt", bus.bubble_cnt, 64'h2);
    checkOutput("mp_stall_cnt", bus.stall_cnt, 64'h1);

    bus.d_in.icode = 4'hA;
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("pre_conf_D_icode", bus.D_out.icode, 64'hA);

    bus.d_in.icode = RET;
    applyStimulus(0, 1, 0, 1, 0, 0);
    tick();
    checkOutput("conf_D_icode", bus.D_out.icode, 64'hA);
    checkOutput("conf_stall_cnt", bus.stall_cnt, 64'h2);
    checkOutput("conf_bubble_cnt", bus.bubble_cnt, 64'h3);

    bus.w_in.stat = AOK;
    bus.w_in.valM = 64'h77;
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("pre_exc_W_valM", bus.W_out.valM, 64'h77);

    // Exception in W: freeze W and keep M empty regardless of incoming status.
    bus.w_in.stat = ADR;
    bus.w_in.valM = 64'h99;
    bus.m_in.stat = ADR;
    bus.m_in.icode = POPQ;
    bus.m_in.valE = 64'hAB;
    applyStimulus(0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("exc_W_valM", bus.W_out.valM, 64'h77);
      checkOutput("exc_W_stat", bus.W_out.stat, 64'h1);
    end
    checkOutput("exc_M_icode", bus.M_out.icode, 64'h1);
    checkOutput("exc_M_stat", bus.M_out.stat, 64'h1);
    checkOutput("exc_M_valE", bus.M_out.valE, 64'h0);
    checkOutput("exc_stall_cnt", bus.stall_cnt, 64'h7);
    checkOutput("exc_bubble_cnt", bus.bubble_cnt, 64'h8);

    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("post_exc_W_stat", bus.W_out.stat, 64'h3);
    checkOutput("post_exc_M_valE", bus.M_out.valE, 64'hAB);

    // Reset arriving during an active stall must still win.
    bus.f_predPC = 64'h300;
    tick();
    applyStimulus(1, 1, 1, 1, 1, 1);
    tick();
    checkOutput("ms_stall_cnt_pre", bus.stall_cnt, 64'h8);
    rst = 1'b1;
    tick();
    checkOutput("ms_F_predPC", bus.F_predPC, 64'h0);
    checkOutput("ms_D_icode", bus.D_out.icode, 64'h1);
    checkOutput("ms_W_stat", bus.W_out.stat, 64'h1);
    checkOutput("ms_stall_cnt", bus.stall_cnt, 64'h0);
    checkOutput("ms_bubble_cnt", bus.bubble_cnt, 64'h0);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("after_rst_F_predPC", bus.F_predPC, 64'h300);

    sat_rst = 1'b0;
    sat.F_stall = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checkOutput("sat_stall_cnt", {60'h0, sat.stall_cnt}, (i > 15) ? 64'd15 : 64'(i));
    end
    checkOutput("sat_bubble_cnt", {60'h0, sat.bubble_cnt}, 64'h0);
    sat_rst = 1'b1;
    tick();
    checkOutput("sat_rst_stall_cnt", {60'h0, sat.stall_cnt}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
